// File: rtl/keypad_scanner_pkg.sv
// Shared constants, FSM encoding and key-mapping helpers for the keypad scanner.
package keypad_scanner_pkg;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 3;
    localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

    // Key codes beyond the ten digits
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } keyState_e;

    // Reading-order position of a key on the pad (row-major, 0..11)
    function automatic logic [3:0] frameBit(input logic [1:0] r, input logic [1:0] c);
        return 4'(r) * 4'd3 + 4'(c);
    endfunction

    // Key code printed on the pad at a given row/column
    function automatic logic [3:0] keyCode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] pos;
        logic [3:0] code;
        pos = frameBit(r, c);
        case (pos)
            4'd9:    code = KEY_STAR;
            4'd10:   code = 4'd0;
            4'd11:   code = KEY_SHARP;
            default: code = pos + 4'd1;
        endcase
        return code;
    endfunction

    // Convert a column-major scan frame (bit 4*col+row) into a vector indexed by key code
    function automatic logic [FRAME_BITS-1:0] frameToKeys(input logic [FRAME_BITS-1:0] frame);
        logic [FRAME_BITS-1:0] keys;
        keys = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                keys[keyCode(2'(r), 2'(c))] = frame[4*c + r];
            end
        end
        return keys;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Whole-frame debouncer: a frame must repeat DEBOUNCE times before it becomes the stable frame.
module key_frame_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frameDone_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    output logic [FRAME_BITS-1:0] stable_o,
    output logic                  upd_o
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);

    logic [FRAME_BITS-1:0] cand_q,   cand_d;
    logic [FRAME_BITS-1:0] stable_q, stable_d;
    logic [DW-1:0]         debCnt_q, debCnt_d;
    logic                  upd_q,    upd_d;

    // Track the candidate frame and promote it to stable exactly once when its count reaches DEBOUNCE
    always_comb begin
        cand_d   = cand_q;
        debCnt_d = debCnt_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (frameDone_i) begin
            if (frame_i == cand_q) begin
                if (debCnt_q != DEB_MAX) begin
                    debCnt_d = debCnt_q + 1'b1;
                    if (debCnt_d == DEB_MAX) begin
                        stable_d = cand_q;
                        upd_d    = 1'b1;
                    end
                end
            end else begin
                cand_d   = frame_i;
                debCnt_d = DEB_ONE;
                if (DEB_MAX == DEB_ONE) begin
                    stable_d = frame_i;
                    upd_d    = 1'b1;
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cand_q   <= '0;
            debCnt_q <= '0;
            stable_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            debCnt_q <= debCnt_d;
            stable_q <= stable_d;
            upd_q    <= upd_d;
        end
    end

    assign stable_o = stable_q;
    assign upd_o    = upd_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, frame capture, debounce and single-shot key strobes.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_CNT = 5000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic [9:0] keypad,
    output logic       sharp,
    output logic       star,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_CNT);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CNT - 1);

    logic [SW-1:0]         slotCnt_q,  slotCnt_d;
    logic [1:0]            colIdx_q,   colIdx_d;
    logic [FRAME_BITS-1:0] frameAcc_q, frameAcc_d;
    logic                  sampleNow;
    logic                  frameDone;

    logic [FRAME_BITS-1:0] stable;
    logic                  upd;
    logic [FRAME_BITS-1:0] keys;
    logic                  singleKey;
    logic                  anyKey;

    keyState_e             state_q,   state_d;
    logic [9:0]            keypad_q,  keypad_d;
    logic                  sharp_q,   sharp_d;
    logic                  star_q,    star_d;
    logic                  keyHeld_q, keyHeld_d;

    assign sampleNow = (slotCnt_q == SLOT_LAST);
    assign frameDone = sampleNow && (colIdx_q == 2'd2);

    // Slot counter, column rotation and row capture into the frame accumulator
    always_comb begin
        slotCnt_d  = slotCnt_q + 1'b1;
        colIdx_d   = colIdx_q;
        frameAcc_d = frameAcc_q;
        if (sampleNow) begin
            slotCnt_d = '0;
            case (colIdx_q)
                2'd0: begin
                    frameAcc_d[3:0] = row;
                    colIdx_d        = 2'd1;
                end
                2'd1: begin
                    frameAcc_d[7:4] = row;
                    colIdx_d        = 2'd2;
                end
                default: begin
                    frameAcc_d[11:8] = row;
                    colIdx_d         = 2'd0;
                end
            endcase
        end
    end

    // Scan state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            slotCnt_q  <= '0;
            colIdx_q   <= 2'd0;
            frameAcc_q <= '0;
        end else begin
            slotCnt_q  <= slotCnt_d;
            colIdx_q   <= colIdx_d;
            frameAcc_q <= frameAcc_d;
        end
    end

    // One-hot column drive from the active column index
    always_comb begin
        case (colIdx_q)
            2'd1:    col = 3'b010;
            2'd2:    col = 3'b100;
            default: col = 3'b001;
        endcase
    end

    key_frame_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) uDebounce (
        .clock       (clock),
        .reset       (reset),
        .frameDone_i (frameDone),
        .frame_i     (frameAcc_d),
        .stable_o    (stable),
        .upd_o       (upd)
    );

    assign keys      = frameToKeys(stable);
    assign anyKey    = (stable != '0);
    assign singleKey = anyKey && ((stable & (stable - 12'd1)) == '0);

    // Key FSM: strobe only on a lone key pressed from an all-released state
    always_comb begin
        state_d   = state_q;
        keypad_d  = '0;
        sharp_d   = 1'b0;
        star_d    = 1'b0;
        keyHeld_d = keyHeld_q;
        if (upd) begin
            keyHeld_d = anyKey;
            case (state_q)
                IDLE: begin
                    if (singleKey) begin
                        keypad_d = keys[9:0];
                        star_d   = keys[KEY_STAR];
                        sharp_d  = keys[KEY_SHARP];
                        state_d  = PRESSED;
                    end else if (anyKey) begin
                        state_d = LOCKED;
                    end
                end
                PRESSED: begin
                    if (!anyKey) begin
                        state_d = IDLE;
                    end else if (!singleKey) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!anyKey) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            keypad_q  <= '0;
            sharp_q   <= 1'b0;
            star_q    <= 1'b0;
            keyHeld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            keypad_q  <= keypad_d;
            sharp_q   <= sharp_d;
            star_q    <= star_d;
            keyHeld_q <= keyHeld_d;
        end
    end

    assign keypad   = keypad_q;
    assign sharp    = sharp_q;
    assign star     = star_q;
    assign key_held = keyHeld_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad front end that produces the decoded key strobes consumed by the nap machine's setting logic: `keypad[9:0]` for digits, `sharp`, and `star`.
- Drives the three columns of a 4x3 telephone keypad one at a time and samples the four rows.
- Debounces whole scan frames and emits exactly one single-cycle strobe per clean key press.
- Sits between the board keypad pins and `main_state` / `shortcutSetting` / `manual_setting`.

Parameters:
- SCAN_CNT, 5000: clock cycles each column is driven (must be ≥2).
- DEBOUNCE, 4: consecutive identical complete frames needed before the stable frame is updated (must be ≥1).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- row, input, 4: row sense lines, active-high; row[0] is the top row.
- col, output, 3: column drive, one-hot, active-high; col[0] is the left column.
- keypad, output, 10: one-cycle strobe; bit n = digit n pressed.
- sharp, output, 1: one-cycle strobe for '#'.
- star, output, 1: one-cycle strobe for '*'.
- key_held, output, 1: level, high while the stable frame has at least one key pressed.

Behaviour:
- Key map (row, col): (0,0..2) = 1,2,3; (1,0..2) = 4,5,6; (2,0..2) = 7,8,9; (3,0) = '*'; (3,1) = 0; (3,2) = '#'.
- Reset values: col = 3'b001; keypad = 0; sharp = 0; star = 0; key_held = 0. All counters, frame registers and the debounce count clear. The FSM goes to IDLE.
- Reset mid-scan or mid-press: all state is discarded. A key still held after reset is treated as a new press once debounced.
- Scan:
  - slot_cnt counts 0..SCAN_CNT-1 per column.
  - When slot_cnt = SCAN_CNT-1, the row value is stored into frame_acc[4*c+3 : 4*c], where c is the active column index.
  - On that same cycle the column advances: col rotates 001 → 010 → 100 → 001.
  - A frame is SCAN_CNT*3 cycles.
  - frame_done pulses on the cycle the column-2 sample is stored.
  - The complete 12-bit frame is frame_acc with the new row nibble merged in.
- Debounce (evaluated when frame_done is high):
  - If the new frame equals cand, increment deb_cnt, saturating at DEBOUNCE.
  - Otherwise load cand with the new frame and set deb_cnt = 1.
  - When deb_cnt reaches DEBOUNCE, load stable with cand. This is done at most once per candidate.
  - With DEBOUNCE = 1, every frame updates stable directly.
- Key FSM: states IDLE, PRESSED, LOCKED. It evaluates only on the cycle after stable updates (upd).
  - IDLE: exactly one bit of stable set → emit that key's strobe and go to PRESSED. Two or more bits set → go to LOCKED with no strobe. Zero bits → stay in IDLE.
  - PRESSED: stable = 0 → IDLE. A second key added → LOCKED with no strobe. Same single key → stay.
  - LOCKED: stable = 0 → IDLE. Otherwise stay; no strobes while LOCKED.
- Strobes:
  - Asserted for exactly one clock, on the cycle after upd.
  - At most one of keypad / sharp / star is high in any cycle, and at most one keypad bit is high.
  - A held key never repeats.
  - A transition from key A directly to key B, without an all-released stable frame in between, does not strobe B.
- key_held = (stable != 0), registered, updating on the same cycle as the strobe.
- Latency: a press that is steady from frame k strobes 2 cycles after the frame_done of frame k+DEBOUNCE-1 (one cycle for upd, one registered output).

Decomposition:
- Shared package holds:
  - key-index constants (KEY_STAR = 10, KEY_SHARP = 11);
  - frame bit-index function: row*3 + col, 12 bits;
  - FSM state encoding (IDLE = 0, PRESSED = 1, LOCKED = 2).
- One natural sub-module: `key_frame_debounce`. It owns the cand/deb_cnt/stable registers and outputs stable plus upd.
- Scan counter, key FSM and decode stay in the top module.

Test Plan (SCAN_CNT=4, DEBOUNCE=3; frame = 12 cycles):
- Reset, then idle for 60 cycles → col cycles 001, 010, 100 every 4 cycles; keypad, sharp, star and key_held stay 0.
- Hold row=4'b0010 only while col=010 (key 5) from frame 0 → keypad=10'b0000100000 for exactly one cycle, 2 cycles after frame 2's frame_done; key_held=1; no repeat over 10 further frames.
- Release key 5 for 3 frames, then press '#' (row[3] during col=100) → sharp pulses once; keypad stays 0. Pressing 0 (row[3] during col=010) → keypad[0] pulses once.
- Glitch key 7 for 2 frames only, then release → no strobe, key_held stays 0.
- Press 1 and 9 simultaneously for 5 frames → no strobe (LOCKED). Release both for 3 frames, then press 3 → keypad[3] pulses once.
- Press key 2 until its strobe, then assert reset for 1 cycle while still holding → all outputs return to reset values; keypad[2] pulses again after 3 more matching frames.
